// File: rtl/text_writer.sv
// Text-mode character RAM writer: takes a character stream, keeps a cursor,
// interprets CR/LF/BS/FF, blanks each new row on a row advance, and blanks
// the whole screen after reset or on a clear request.
module text_writer #(
  parameter int           COLS     = 40,
  parameter int           ROWS     = 30,
  parameter int           COL_BITS = 6,
  parameter int           ROW_BITS = 5,
  parameter logic [7:0]   BLANK    = 8'h20
) (
  input  logic                         px_clk,
  input  logic                         rstn,
  input  logic                         in_valid,
  input  logic [7:0]                   in_char,
  output logic                         in_ready,
  input  logic                         clear,
  output logic                         busy,
  output logic                         write_en,
  output logic [ROW_BITS+COL_BITS-1:0] waddr,
  output logic [7:0]                   wdata,
  output logic [COL_BITS-1:0]          cursor_x,
  output logic [ROW_BITS-1:0]          cursor_y
);

  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_LINECLR
  } state_t;

  state_t                        r_state;
  logic [ROW_BITS-1:0]           r_clrRow;
  logic [COL_BITS-1:0]           r_clrCol;
  logic [COL_BITS-1:0]           r_curX;
  logic [ROW_BITS-1:0]           r_curY;
  logic                          r_we;
  logic [ROW_BITS+COL_BITS-1:0]  r_addr;
  logic [7:0]                    r_data;

  logic                          w_printable;
  logic [ROW_BITS-1:0]           w_nextY;
  logic [COL_BITS-1:0]           w_prevX;

  assign w_printable = ((in_char >= 8'h20) && (in_char <= 8'h7E)) || in_char[7];
  assign w_nextY     = (r_curY == LAST_ROW) ? '0 : r_curY + 1'b1;
  assign w_prevX     = r_curX - 1'b1;

  assign in_ready = (r_state == S_IDLE) && !clear;
  assign busy     = (r_state != S_IDLE);
  assign write_en = r_we;
  assign waddr    = r_addr;
  assign wdata    = r_data;
  assign cursor_x = r_curX;
  assign cursor_y = r_curY;

  // Single FSM: clear has top priority and restarts the screen blank; the
  // blank counters are shared by the full clear and the single-row clear.
  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_CLEAR;
      r_clrRow <= '0;
      r_clrCol <= '0;
      r_curX   <= '0;
      r_curY   <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      r_we <= 1'b0;
      if (clear) begin
        r_state  <= S_CLEAR;
        r_clrRow <= '0;
        r_clrCol <= '0;
        r_curX   <= '0;
        r_curY   <= '0;
      end else begin
        case (r_state)
          S_CLEAR: begin
            r_we   <= 1'b1;
            r_addr <= {r_clrRow, r_clrCol};
            r_data <= BLANK;
            r_curX <= '0;
            r_curY <= '0;
            if (r_clrCol == LAST_COL) begin
              r_clrCol <= '0;
              if (r_clrRow == LAST_ROW) begin
                r_clrRow <= '0;
                r_state  <= S_IDLE;
              end else begin
                r_clrRow <= r_clrRow + 1'b1;
              end
            end else begin
              r_clrCol <= r_clrCol + 1'b1;
            end
          end

          S_LINECLR: begin
            r_we   <= 1'b1;
            r_addr <= {r_curY, r_clrCol};
            r_data <= BLANK;
            if (r_clrCol == LAST_COL) begin
              r_clrCol <= '0;
              r_state  <= S_IDLE;
            end else begin
              r_clrCol <= r_clrCol + 1'b1;
            end
          end

          S_IDLE: begin
            if (in_valid) begin
              if (w_printable) begin
                r_we   <= 1'b1;
                r_addr <= {r_curY, r_curX};
                r_data <= in_char;
                if (r_curX == LAST_COL) begin
                  r_curX   <= '0;
                  r_curY   <= w_nextY;
                  r_clrCol <= '0;
                  r_state  <= S_LINECLR;
                end else begin
                  r_curX <= r_curX + 1'b1;
                end
              end else begin
                case (in_char)
                  8'h0D: r_curX <= '0;
                  8'h0A: begin
                    r_curX   <= '0;
                    r_curY   <= w_nextY;
                    r_clrCol <= '0;
                    r_state  <= S_LINECLR;
                  end
                  8'h08: begin
                    if (r_curX != '0) begin
                      r_curX <= w_prevX;
                      r_we   <= 1'b1;
                      r_addr <= {r_curY, w_prevX};
                      r_data <= BLANK;
                    end
                  end
                  8'h0C: begin
                    r_state  <= S_CLEAR;
                    r_clrRow <= '0;
                    r_clrCol <= '0;
                    r_curX   <= '0;
                    r_curY   <= '0;
                  end
                  default: ;
                endcase
              end
            end
          end

          default: begin
            r_state  <= S_CLEAR;
            r_clrRow <= '0;
            r_clrCol <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_text_writer.sv
// Bench for text_writer: a screen-level model predicts the ordered list of
// RAM writes and the cursor; a monitor pops that list on every write strobe.
module tb_text_writer;

  localparam int COLS = 40;
  localparam int ROWS = 30;

  logic        px_clk   = 1'b0;
  logic        rstn     = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_char  = 8'h00;
  logic        clear    = 1'b0;
  wire         in_ready;
  wire         busy;
  wire         write_en;
  wire  [10:0] waddr;
  wire  [7:0]  wdata;
  wire  [5:0]  cursor_x;
  wire  [4:0]  cursor_y;

  text_writer dut (
    .px_clk   (px_clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_char  (in_char),
    .in_ready (in_ready),
    .clear    (clear),
    .busy     (busy),
    .write_en (write_en),
    .waddr    (waddr),
    .wdata    (wdata),
    .cursor_x (cursor_x),
    .cursor_y (cursor_y)
  );

  // Free-running pixel clock
  always #5 px_clk = ~px_clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [18:0] expQ[$];
  int mx = 0;
  int my = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic void pushWrite(input int x, input int y, input logic [7:0] d);
    logic [5:0] xx;
    logic [4:0] yy;
    xx = x[5:0];
    yy = y[4:0];
    expQ.push_back({yy, xx, d});
  endfunction

  function automatic void modelClear();
    expQ.delete();
    mx = 0;
    my = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        pushWrite(c, r, 8'h20);
  endfunction

  function automatic void modelRowAdvance();
    mx = 0;
    my = (my == ROWS - 1) ? 0 : my + 1;
    for (int c = 0; c < COLS; c++)
      pushWrite(c, my, 8'h20);
  endfunction

  function automatic bit isPrintable(input logic [7:0] c);
    return ((c >= 8'h20) && (c <= 8'h7E)) || (c >= 8'h80);
  endfunction

  function automatic void modelChar(input logic [7:0] c);
    if (isPrintable(c)) begin
      pushWrite(mx, my, c);
      if (mx == COLS - 1) modelRowAdvance();
      else mx++;
    end else if (c == 8'h0D) begin
      mx = 0;
    end else if (c == 8'h0A) begin
      modelRowAdvance();
    end else if (c == 8'h08) begin
      if (mx > 0) begin
        mx--;
        pushWrite(mx, my, 8'h20);
      end
    end else if (c == 8'h0C) begin
      modelClear();
    end
  endfunction

  task automatic tick();
    @(negedge px_clk);
    #1;
  endtask

  // Every write strobe must be the next write the model predicted
  always @(negedge px_clk) begin : monitor
    logic [18:0] e;
    if (rstn && write_en) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_write", {21'h0, waddr}, 32'h7FF);
      end else begin
        e = expQ.pop_front();
        checkOutput("write_addr_data", {13'h0, waddr, wdata}, {13'h0, e});
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] c);
    int budget;
    budget   = 0;
    in_char  = c;
    in_valid = 1'b1;
    while (!in_ready && budget < 3000) begin
      tick();
      budget++;
    end
    if (!in_ready) begin
      checkOutput("ready_timeout", {31'h0, in_ready}, 32'h1);
      in_valid = 1'b0;
      return;
    end
    modelChar(c);
    tick();
    in_valid = 1'b0;
    checkOutput("cursor_x", {26'h0, cursor_x}, mx);
    checkOutput("cursor_y", {27'h0, cursor_y}, my);
  endtask

  task automatic runClearCheck(input int expCycles);
    int cycles;
    int pulses;
    cycles = 0;
    pulses = 0;
    while (cycles < 3000) begin
      tick();
      cycles++;
      if (write_en) pulses++;
      if (in_ready) break;
    end
    checkOutput("clear_cycles", cycles, expCycles);
    checkOutput("clear_pulses", pulses, ROWS * COLS);
    checkOutput("ready_on_last_write", {31'h0, write_en}, 32'h1);
    checkOutput("busy_after_clear", {31'h0, busy}, 32'h0);
    checkOutput("cursor_after_clear", {21'h0, cursor_y, cursor_x}, 32'h0);
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    modelClear();
    tick();
    clear = 1'b0;
  endtask

  task automatic waitDrain();
    int budget;
    budget = 0;
    while ((expQ.size() != 0 || !in_ready) && budget < 3000) begin
      tick();
      budget++;
    end
    checkOutput("drain_pending", expQ.size(), 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_we"},     {31'h0, write_en}, 32'h0);
    checkOutput({tag, "_waddr"},  {21'h0, waddr},    32'h0);
    checkOutput({tag, "_wdata"},  {24'h0, wdata},    32'h0);
    checkOutput({tag, "_cursor"}, {21'h0, cursor_y, cursor_x}, 32'h0);
    checkOutput({tag, "_busy"},   {31'h0, busy},     32'h1);
    checkOutput({tag, "_ready"},  {31'h0, in_ready}, 32'h0);
  endtask

  function automatic logic [7:0] randomChar();
    int r;
    logic [7:0] ctl [5];
    ctl[0] = 8'h00; ctl[1] = 8'h01; ctl[2] = 8'h1B; ctl[3] = 8'h7F; ctl[4] = 8'h09;
    r = $urandom_range(0, 99);
    if (r < 30) return 8'($urandom_range(8'h20, 8'h7E));
    if (r < 60) return 8'($urandom_range(8'h80, 8'hFF));
    if (r < 70) return 8'h0D;
    if (r < 80) return 8'h0A;
    if (r < 90) return 8'h08;
    if (r < 99) return ctl[$urandom_range(0, 4)];
    return 8'h0C;
  endfunction

  // Directed scenarios followed by a random character stream
  initial begin
    tick();
    tick();
    checkResetValues("reset");

    rstn = 1'b1;
    modelClear();
    runClearCheck(ROWS * COLS);

    applyStimulus(8'h41);
    applyStimulus(8'h42);
    applyStimulus(8'h08);
    checkOutput("bs_cursor_x", {26'h0, cursor_x}, 32'd1);
    waitDrain();

    pulseClear();
    runClearCheck(ROWS * COLS);
    for (int i = 0; i < COLS; i++) applyStimulus(8'h41 + 8'(i % 26));
    begin
      int low;
      low = 0;
      while (!in_ready && low < 200) begin
        low++;
        tick();
      end
      checkOutput("lineclr_ready_low", low, COLS);
    end
    checkOutput("wrap_cursor", {21'h0, cursor_y, cursor_x}, {21'h0, 5'd1, 6'd0});
    waitDrain();

    for (int i = 0; i < 28; i++) applyStimulus(8'h0A);
    for (int i = 0; i < 5; i++) applyStimulus(8'h61 + 8'(i));
    applyStimulus(8'h0A);
    checkOutput("lf_wrap_cursor", {21'h0, cursor_y, cursor_x}, 32'h0);
    waitDrain();
    for (int i = 0; i < 3; i++) applyStimulus(8'h0A);
    for (int i = 0; i < 7; i++) applyStimulus(8'h30 + 8'(i));
    applyStimulus(8'h0D);
    checkOutput("cr_cursor", {21'h0, cursor_y, cursor_x}, {21'h0, 5'd3, 6'd0});
    waitDrain();

    for (int i = 0; i < COLS; i++) applyStimulus(8'h50);
    in_char  = 8'h5A;
    in_valid = 1'b1;
    repeat (19) tick();
    checkOutput("lineclr_busy", {31'h0, busy}, 32'h1);
    pulseClear();
    runClearCheck(ROWS * COLS);
    modelChar(8'h5A);
    tick();
    in_valid = 1'b0;
    checkOutput("held_char_cursor", {21'h0, cursor_y, cursor_x}, {21'h0, 5'd0, 6'd1});
    waitDrain();

    pulseClear();
    repeat (600) tick();
    rstn = 1'b0;
    #1;
    checkResetValues("midreset");
    expQ.delete();
    mx = 0;
    my = 0;
    repeat (3) tick();
    rstn = 1'b1;
    modelClear();
    runClearCheck(ROWS * COLS);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(randomChar());
      repeat ($urandom_range(0, 2)) tick();
    end
    waitDrain();
    repeat (5) tick();
    checkOutput("final_queue_empty", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
